// File: rtl/bias_buffer.sv
// rtl/bias_buffer.sv - loads packed biases from weight SRAM and serves one signed bias per lookup
module bias_buffer #(
    parameter int BIAS_W        = 4,
    parameter int BIAS_PER_WORD = 25,
    parameter int NUM_WORDS     = 2,
    parameter int ADDR_W        = 17,
    parameter int SEL_W         = 8,
    parameter int SRAM_LAT      = 1
) (
    input  logic                                clk,
    input  logic                                srstn,
    input  logic                                load_start,
    input  logic [ADDR_W-1:0]                   load_base,
    input  logic [$clog2(NUM_WORDS+1)-1:0]      load_beats,
    output logic [ADDR_W-1:0]                   sram_raddr_weight,
    output logic                                sram_rd_en,
    input  logic [BIAS_W*BIAS_PER_WORD-1:0]     sram_rdata_weight,
    output logic                                load_busy,
    output logic                                load_done,
    input  logic                                sel_valid,
    input  logic [SEL_W-1:0]                    sel,
    output logic                                sel_ready,
    output logic signed [BIAS_W-1:0]            bias_data,
    output logic                                bias_valid,
    output logic                                sel_err
);

    localparam int NUM_BIAS = BIAS_PER_WORD * NUM_WORDS;
    localparam int BEAT_W   = $clog2(NUM_WORDS + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                     state, state_nxt;
    logic [BEAT_W-1:0]          beats_q;
    logic [BEAT_W-1:0]          beat_k;
    logic [BEAT_W-1:0]          beats_eff;
    logic                       zero_done;
    logic [SRAM_LAT-1:0]        pipe_v;
    logic [SRAM_LAT-1:0]        pipe_last;
    logic [BEAT_W-1:0]          pipe_k [SRAM_LAT];
    logic signed [BIAS_W-1:0]   bias_mem [NUM_BIAS];
    logic signed [BIAS_W-1:0]   bias_sel;
    logic                       accept;
    logic                       last_issue;
    logic                       cap_v;
    logic                       cap_last;
    logic [BEAT_W-1:0]          cap_k;
    logic                       lookup_fire;
    logic                       sel_oob;

    assign beats_eff   = (32'(load_beats) > NUM_WORDS) ? BEAT_W'(NUM_WORDS) : load_beats;
    assign accept      = load_start && (state == IDLE);
    assign last_issue  = (state == ISSUE) && (beat_k == beats_q - BEAT_W'(1));

    // Tail of the tag pipeline lines up with the rdata of the read issued SRAM_LAT cycles ago
    assign cap_v       = pipe_v[SRAM_LAT-1];
    assign cap_last    = pipe_last[SRAM_LAT-1];
    assign cap_k       = pipe_k[SRAM_LAT-1];

    assign load_done   = (cap_v && cap_last) || zero_done;
    assign load_busy   = (state != IDLE);
    assign sram_rd_en  = (state == ISSUE);
    assign sel_ready   = ~load_busy;
    assign lookup_fire = sel_valid && sel_ready;
    assign sel_oob     = 32'(sel) >= NUM_BIAS;

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (beats_eff == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (load_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            beats_q           <= '0;
            beat_k            <= '0;
            zero_done         <= 1'b0;
            sram_raddr_weight <= '0;
            pipe_v            <= '0;
            pipe_last         <= '0;
            for (int i = 0; i < SRAM_LAT; i++) begin
                pipe_k[i] <= '0;
            end
        end else begin
            zero_done <= accept && (beats_eff == '0);
            if (accept) begin
                beats_q <= beats_eff;
                beat_k  <= '0;
                if (beats_eff != '0) begin
                    sram_raddr_weight <= load_base;
                end
            end else if (sram_rd_en && !last_issue) begin
                beat_k            <= beat_k + BEAT_W'(1);
                sram_raddr_weight <= sram_raddr_weight + ADDR_W'(1);
            end
            pipe_v[0]    <= sram_rd_en;
            pipe_last[0] <= last_issue;
            pipe_k[0]    <= beat_k;
            for (int i = 1; i < SRAM_LAT; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_last[i] <= pipe_last[i-1];
                pipe_k[i]    <= pipe_k[i-1];
            end
        end
    end

    // First bias of a word sits in its MSBs
    always_ff @(posedge clk) begin
        if (!srstn) begin
            for (int s = 0; s < NUM_BIAS; s++) begin
                bias_mem[s] <= '0;
            end
        end else if (cap_v) begin
            for (int s = 0; s < NUM_BIAS; s++) begin
                if (32'(cap_k) == s / BIAS_PER_WORD) begin
                    bias_mem[s] <= sram_rdata_weight[(BIAS_PER_WORD-1-(s%BIAS_PER_WORD))*BIAS_W +: BIAS_W];
                end
            end
        end
    end

    always_comb begin
        bias_sel = '0;
        for (int s = 0; s < NUM_BIAS; s++) begin
            if (32'(sel) == s) begin
                bias_sel = bias_mem[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            bias_data  <= '0;
            bias_valid <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            bias_valid <= lookup_fire;
            sel_err    <= lookup_fire && sel_oob;
            if (lookup_fire) begin
                bias_data <= bias_sel;
            end
        end
    end

endmodule

// File: tb/tb_bias_buffer.sv
// tb/tb_bias_buffer.sv - scoreboard bench for bias_buffer at SRAM latency 1 and 3
module tb_bias_buffer;

    typedef struct packed {
        logic [3:0] data;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        srstn;
    logic        load_start;
    logic [16:0] load_base;
    logic [1:0]  load_beats;
    logic [7:0]  sel;
    logic [1:0]  sel_valid;

    logic [16:0] raddr [2];
    logic        rd_en [2];
    logic [99:0] rdata [2];
    logic        load_busy [2];
    logic        load_done [2];
    logic        sel_ready [2];
    logic [3:0]  bias_data [2];
    logic        bias_valid [2];
    logic        sel_err [2];

    logic [99:0] mem [16];
    logic [16:0] apipe [2][3];
    logic [3:0]  model [50];
    exp_t        sbq0 [$];
    exp_t        sbq1 [$];
    exp_t        e0, e1;
    exp_t        last_exp [2];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    bias_buffer #(.SRAM_LAT(1)) dut0 (
        .clk(clk), .srstn(srstn), .load_start(load_start), .load_base(load_base),
        .load_beats(load_beats), .sram_raddr_weight(raddr[0]), .sram_rd_en(rd_en[0]),
        .sram_rdata_weight(rdata[0]), .load_busy(load_busy[0]), .load_done(load_done[0]),
        .sel_valid(sel_valid[0]), .sel(sel), .sel_ready(sel_ready[0]), .bias_data(bias_data[0]),
        .bias_valid(bias_valid[0]), .sel_err(sel_err[0])
    );

    bias_buffer #(.SRAM_LAT(3)) dut1 (
        .clk(clk), .srstn(srstn), .load_start(load_start), .load_base(load_base),
        .load_beats(load_beats), .sram_raddr_weight(raddr[1]), .sram_rd_en(rd_en[1]),
        .sram_rdata_weight(rdata[1]), .load_busy(load_busy[1]), .load_done(load_done[1]),
        .sel_valid(sel_valid[1]), .sel(sel), .sel_ready(sel_ready[1]), .bias_data(bias_data[1]),
        .bias_valid(bias_valid[1]), .sel_err(sel_err[1])
    );

    // SRAM model: rdata follows the address presented 1 (dut0) or 3 (dut1) cycles earlier
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            apipe[d][2] <= apipe[d][1];
            apipe[d][1] <= apipe[d][0];
            apipe[d][0] <= raddr[d];
        end
    end
    assign rdata[0] = mem[apipe[0][0][3:0]];
    assign rdata[1] = mem[apipe[1][2][3:0]];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge clk) begin
        #1;
        if (bias_valid[0]) begin
            if (sbq0.size() == 0) check("unexpected_valid0", 1, 0);
            else begin
                e0 = sbq0.pop_front();
                check("bias_data0", bias_data[0], e0.data);
                check("sel_err0", sel_err[0], e0.err);
            end
        end
        if (sel_err[0] && !bias_valid[0]) check("err_without_valid0", 1, 0);
        if (bias_valid[1]) begin
            if (sbq1.size() == 0) check("unexpected_valid1", 1, 0);
            else begin
                e1 = sbq1.pop_front();
                check("bias_data1", bias_data[1], e1.data);
                check("sel_err1", sel_err[1], e1.err);
            end
        end
        if (sel_err[1] && !bias_valid[1]) check("err_without_valid1", 1, 0);
    end

    task automatic push_entry(input int d, input exp_t e);
        last_exp[d] = e;
        if (d == 0) sbq0.push_back(e);
        else sbq1.push_back(e);
    endtask

    task automatic push_model(input int d, input int s);
        exp_t e;
        e.data = (s < 50) ? model[s] : 4'h0;
        e.err  = (s >= 50);
        push_entry(d, e);
    endtask

    task automatic finish_lookups();
        @(negedge clk);
        sel_valid = 2'b00;
        repeat (2) @(negedge clk);
        check("sb_empty0", sbq0.size(), 0);
        check("sb_empty1", sbq1.size(), 0);
        for (int d = 0; d < 2; d++) check("bias_hold", bias_data[d], last_exp[d].data);
    endtask

    task automatic lookup_seq(input int sels[$]);
        foreach (sels[i]) begin
            @(negedge clk);
            sel_valid = 2'b11;
            sel = 8'(sels[i]);
            for (int d = 0; d < 2; d++) begin
                check("sel_ready_idle", sel_ready[d], 1);
                push_model(d, sels[i]);
            end
        end
        finish_lookups();
    endtask

    task automatic lookup_all();
        int q[$];
        for (int i = 0; i < 50; i++) q.push_back(i);
        lookup_seq(q);
    endtask

    task automatic lookup_const(input int s, input logic [3:0] v);
        exp_t e;
        e.data = v;
        e.err  = 1'b0;
        @(negedge clk);
        sel_valid = 2'b11;
        sel = 8'(s);
        for (int d = 0; d < 2; d++) push_entry(d, e);
        finish_lookups();
    endtask

    task automatic do_load(input logic [16:0] base, input logic [1:0] beats, input bit hold_sel,
                           input int hold_s, input bit restart, input int same_sel);
        int eff;
        int cyc;
        int exp_done [2];
        int nissue [2];
        bit done [2];
        bit served [2];
        logic [99:0] w;
        eff = (beats > 2) ? 2 : int'(beats);
        for (int d = 0; d < 2; d++) begin
            exp_done[d] = (eff == 0) ? 1 : eff + ((d == 0) ? 1 : 3);
            nissue[d] = 0;
            done[d] = 1'b0;
            served[d] = !hold_sel;
        end
        @(negedge clk);
        load_start = 1'b1;
        load_base  = base;
        load_beats = beats;
        if (same_sel >= 0) begin
            sel_valid = 2'b11;
            sel = 8'(same_sel);
            for (int d = 0; d < 2; d++) begin
                check("sel_ready_same_cycle", sel_ready[d], 1);
                push_model(d, same_sel);
            end
        end
        for (int k = 0; k < eff; k++) begin
            w = mem[4'(base + 17'(k))];
            for (int j = 0; j < 25; j++) model[k*25+j] = w[(24-j)*4 +: 4];
        end
        cyc = 0;
        while (!(done[0] && done[1] && served[0] && served[1]) && cyc < 30) begin
            @(negedge clk);
            cyc++;
            load_start = restart && (cyc == 1);
            if (restart && cyc == 1) begin
                load_base  = base + 17'd8;
                load_beats = 2'd1;
            end
            if (same_sel >= 0 && cyc == 1) sel_valid = 2'b00;
            if (hold_sel && cyc == 1) begin
                sel_valid = 2'b11;
                sel = 8'(hold_s);
            end
            for (int d = 0; d < 2; d++) begin
                if (hold_sel && served[d]) sel_valid[d] = 1'b0;
                if (!done[d]) begin
                    check("load_busy", load_busy[d], 1);
                    if (rd_en[d]) begin
                        check("raddr", raddr[d], base + 17'(nissue[d]));
                        check("issue_cycle", cyc, nissue[d] + 1);
                        nissue[d]++;
                    end
                    if (hold_sel) begin
                        check("sel_ready_busy", sel_ready[d], 0);
                        check("no_valid_busy", bias_valid[d], 0);
                    end
                    if (load_done[d]) begin
                        check("done_cycle", cyc, exp_done[d]);
                        check("beats_issued", nissue[d], eff);
                        done[d] = 1'b1;
                    end
                end else if (!served[d]) begin
                    check("sel_ready_after_done", sel_ready[d], 1);
                    push_model(d, hold_s);
                    served[d] = 1'b1;
                end
            end
        end
        for (int d = 0; d < 2; d++) check("load_done_seen", done[d], 1);
        @(negedge clk);
        load_start = 1'b0;
        sel_valid  = 2'b00;
        for (int d = 0; d < 2; d++) begin
            check("idle_after_load", load_busy[d], 0);
            check("done_single_pulse", load_done[d], 0);
            check("rd_en_idle", rd_en[d], 0);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int oob[$];
        int seen;
        srstn = 1'b0;
        load_start = 1'b0;
        load_base = '0;
        load_beats = '0;
        sel = '0;
        sel_valid = 2'b00;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        for (int i = 0; i < 50; i++) model[i] = 4'h0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_raddr", raddr[d], 0);
            check("rst_rd_en", rd_en[d], 0);
            check("rst_busy", load_busy[d], 0);
            check("rst_done", load_done[d], 0);
            check("rst_bias_data", bias_data[d], 0);
            check("rst_bias_valid", bias_valid[d], 0);
            check("rst_sel_err", sel_err[d], 0);
        end
        srstn = 1'b1;
        @(negedge clk);
        lookup_all();

        mem[0] = 100'h123456789ABCDEF0123456789;
        mem[1] = {25{4'hF}};
        do_load(17'h100, 2'd2, 1'b0, 0, 1'b0, -1);
        lookup_const(24, 4'h9);
        lookup_const(25, 4'hF);
        lookup_const(49, 4'hF);
        lookup_all();

        mem[4] = 100'hFEDCBA9876543210FEDCBA987;
        do_load(17'h104, 2'd1, 1'b0, 0, 1'b0, -1);
        lookup_all();

        mem[8] = 100'h0F1E2D3C4B5A69788796A5B4C;
        mem[9] = 100'h7070707070707070707070707;
        do_load(17'h108, 2'd2, 1'b1, 30, 1'b0, -1);
        oob = '{50, 255};
        lookup_seq(oob);

        do_load(17'h100, 2'd2, 1'b0, 0, 1'b1, -1);
        lookup_all();

        mem[5] = 100'h8888444422221111CCCC99995;
        do_load(17'h104, 2'd3, 1'b0, 0, 1'b0, 26);
        lookup_all();

        mem[12] = {25{4'h5}};
        @(negedge clk);
        load_start = 1'b1;
        load_base  = 17'h10C;
        load_beats = 2'd1;
        @(negedge clk);
        load_start = 1'b0;
        @(negedge clk);
        check("drain_busy", load_busy[1], 1);
        check("drain_no_issue", rd_en[1], 0);
        srstn = 1'b0;
        @(negedge clk);
        srstn = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            for (int d = 0; d < 2; d++) if (load_done[d]) seen++;
            @(negedge clk);
        end
        check("no_done_after_reset", seen, 0);
        for (int d = 0; d < 2; d++) begin
            check("idle_after_reset", load_busy[d], 0);
            check("ready_after_reset", sel_ready[d], 1);
            check("raddr_after_reset", raddr[d], 0);
        end
        for (int i = 0; i < 50; i++) model[i] = 4'h0;
        lookup_all();

        do_load(17'h10C, 2'd0, 1'b0, 0, 1'b0, -1);
        for (int d = 0; d < 2; d++) check("raddr_zero_beats", raddr[d], 0);
        lookup_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
